lnext_responder: RTL and testbench

LNEXT_RESPONDER -- requirements
Module: lnext_responder

---
 rtl/lnext_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_lnext_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lnext_responder.sv
// lnext_responder: cache line read responder.
// READ_OUT requests (line addresses) are queued in a small FIFO. Each
// request is served after a fixed idle latency as a burst of BEATS 32-bit
// words, where each word is {line_addr, beat_index}. The consumer applies
// backpressure with rsp_ready.
// Optional statistics counters are built only when the macro
// LNEXT_RESPONDER_STATS_EN is defined. Otherwise the two statistics outputs
// are tied to zero and no counter registers exist.
module lnext_responder #(
    parameter int LATENCY = 4,   // idle cycles from request pop to first beat (1..15)
    parameter int BEATS   = 64,  // words per line burst (power of 2, 2..64)
    parameter int DEPTH   = 4    // request FIFO entries (power of 2)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  cmd_in,
    input  logic [25:0] add_in,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    input  logic        rsp_ready,
    output logic [31:0] reads_served,
    output logic [31:0] stall_cycles
);

    localparam int BW = $clog2(BEATS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0]    CMD_READ_OUT = 2'd1;
    localparam logic [3:0]    WAIT_LOAD    = 4'(LATENCY - 1);
    localparam logic [BW-1:0] LAST_BEAT    = BW'(BEATS - 1);
    localparam logic [PW-1:0] PTR_LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_e;

    state_e state_q, state_d;

    // Request FIFO storage and bookkeeping
    logic [25:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Burst datapath
    logic [3:0]    wait_q, wait_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [25:0]   line_q, line_d;
    logic [63:0]   beat_word;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic beat_hs;
    logic last_hs;

    // Full and empty come from the registered occupancy only, so a pop in
    // the same cycle never lets an extra request in.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign req_ready  = !fifo_full;
    assign push       = (cmd_in == CMD_READ_OUT) && !fifo_full;

    // Handshake terms are derived from the state register, not from the
    // rsp_valid output, so there is no combinational path through the output.
    assign beat_hs = (state_q == ST_BURST) && rsp_ready;
    assign last_hs = beat_hs && (beat_q == LAST_BEAT);

    // The word is {line, beat}. It is at most 32 bits wide for legal BEATS,
    // and it is zero-extended into the 64-bit holder.
    assign beat_word = 64'({line_q, beat_q});

    // State register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of block order.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first; every path then assigns state_d,
        // so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (last_hs) begin
                    state_d = fifo_empty ? ST_IDLE : ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: response signals and the FIFO pop strobe
    always_comb begin
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_data  = '0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop = !fifo_empty;
            end
            ST_BURST: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat_q == LAST_BEAT);
                rsp_data  = beat_word[31:0];
                pop       = last_hs && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Datapath next-state: FIFO pointers, occupancy, wait counter, beat index
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;
        beat_d   = beat_q;
        line_d   = line_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        // beat_q moves only on a handshake, which keeps data and last
        // stable while the consumer stalls.
        if (beat_hs) begin
            beat_d = beat_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            line_d   = fifo_mem[rd_ptr_q];
            wait_d   = WAIT_LOAD;
            beat_d   = '0;
        end else if ((state_q == ST_WAIT) && (wait_q != '0)) begin
            wait_d = wait_q - 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            beat_q   <= '0;
            line_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset. Cleared pointers and
        // occupancy make stale entries unreachable.
        if (push && !reset) begin
            fifo_mem[wr_ptr_q] <= add_in;
        end
    end

`ifdef LNEXT_RESPONDER_STATS_EN
    logic [31:0] reads_q, reads_d;
    logic [31:0] stalls_q, stalls_d;

    // Saturating statistics: completed bursts and stalled beat cycles
    always_comb begin
        reads_d  = reads_q;
        stalls_d = stalls_q;
        if (last_hs && (reads_q != '1)) begin
            reads_d = reads_q + 1'b1;
        end
        if ((state_q == ST_BURST) && !rsp_ready && (stalls_q != '1)) begin
            stalls_d = stalls_q + 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (reset) begin
            reads_q  <= '0;
            stalls_q <= '0;
        end else begin
            reads_q  <= reads_d;
            stalls_q <= stalls_d;
        end
    end

    assign reads_served = reads_q;
    assign stall_cycles = stalls_q;
`else
    assign reads_served = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_lnext_responder.sv
// tb_lnext_responder: directed scenarios plus randomized bursts for
// lnext_responder. Expected beats come from a line-address queue. Each word
// is line * BEATS + beat_index, computed arithmetically. Statistics
// expectations follow LNEXT_RESPONDER_STATS_EN.
module tb_lnext_responder;

    localparam int LATENCY = 4;
    localparam int BEATS   = 64;
    localparam int DEPTH   = 4;

`ifdef LNEXT_RESPONDER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clock;
    logic        reset;
    logic [1:0]  cmd_in;
    logic [25:0] add_in;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_ready;
    logic [31:0] reads_served;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    lnext_responder #(
        .LATENCY(LATENCY),
        .BEATS  (BEATS),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_in      (cmd_in),
        .add_in      (add_in),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .rsp_ready   (rsp_ready),
        .reads_served(reads_served),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then sample just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] model_word(input logic [25:0] line, input int beat);
        longint w;
        w = longint'(line) * BEATS + beat;
        return w[31:0];
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        cmd_in    = 2'd0;
        add_in    = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_req(input logic [25:0] line);
        cmd_in = 2'd1;
        add_in = line;
        tick();
        cmd_in = 2'd0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
    endtask

    // Consume nbeats beats of the burst for 'line'.
    // policy 0 = always ready, 1 = toggle from first valid, 2 = random.
    // gap counts invalid cycles before the first beat.
    task automatic receive_burst(input logic [25:0] line, input int policy, input int nbeats,
                                 input string tag, output int gap, output int stalls);
        int  beat    = 0;
        int  budget  = 0;
        bit  started = 0;
        gap    = 0;
        stalls = 0;
        case (policy)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
        while (beat < nbeats && budget < 5000) begin
            if (rsp_valid) begin
                started = 1;
                check($sformatf("%s data beat %0d", tag, beat), rsp_data, model_word(line, beat));
                check($sformatf("%s last beat %0d", tag, beat), 32'(rsp_last),
                      32'(beat == BEATS - 1));
                if (rsp_ready) beat++;
                else stalls++;
            end else if (!started) begin
                gap++;
            end else begin
                check($sformatf("%s valid held at beat %0d", tag, beat), 32'(rsp_valid), 32'd1);
            end
            tick();
            budget++;
            if (policy == 1 && started) rsp_ready = ~rsp_ready;
            else if (policy == 2) rsp_ready = 1'($urandom_range(0, 1));
        end
        if (budget >= 5000) check($sformatf("%s beats before timeout", tag), 32'(beat), 32'(nbeats));
    endtask

    initial begin
        logic [25:0] lines [5];
        logic [25:0] qline [$];
        int gap, stalls, seen, e, total, k;

        // ---- reset state ----
        do_reset();
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_last", 32'(rsp_last), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset reads_served", reads_served, 32'd0);
        check("reset stall_cycles", stall_cycles, 32'd0);

        // ---- single READ_OUT: latency, data, last ----
        rsp_ready = 1'b1;
        push_req(26'h0000ABC);          // edge 0
        e = 0;
        while (!rsp_valid && e < 50) begin
            tick();
            e++;
        end
        // Valid visible after edge e is first sampled at edge e+1.
        check("first beat edge", 32'(e + 1), 32'(LATENCY + 2));
        check("first beat data", rsp_data, 32'h0002AF00);
        receive_burst(26'h0000ABC, 0, BEATS, "single", gap, stalls);
        check("single stalls", 32'(stalls), 32'd0);
        check("single reads_served", reads_served, 32'(STATS));
        check("single final valid", 32'(rsp_valid), 32'd0);

        // ---- reserved commands ignored ----
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_in = (i % 2 == 0) ? 2'd2 : 2'd3;
            add_in = 26'($urandom);
            tick();
        end
        cmd_in = 2'd0;
        check("reserved cmd req_ready", 32'(req_ready), 32'd1);
        count_valid(20, seen);
        check("reserved cmd valid cycles", 32'(seen), 32'd0);

        // ---- FIFO full with FSM busy, ordered bursts ----
        do_reset();
        for (int i = 0; i < 5; i++) lines[i] = 26'($urandom);
        push_req(26'h1234567);
        wait_valid("busy first valid");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full req_ready before push %0d", i), 32'(req_ready), 32'(i < DEPTH));
            cmd_in = 2'd1;
            add_in = lines[i];
            tick();
        end
        cmd_in = 2'd0;
        receive_burst(26'h1234567, 0, BEATS, "busy head", gap, stalls);
        for (int i = 0; i < DEPTH; i++) begin
            receive_burst(lines[i], 0, BEATS, $sformatf("queued %0d", i), gap, stalls);
            check($sformatf("queued %0d gap", i), 32'(gap), 32'(LATENCY));
        end
        count_valid(30, seen);
        check("fifth request dropped", 32'(seen), 32'd0);
        check("full reads_served", reads_served, 32'(STATS * (DEPTH + 1)));

        // ---- toggled rsp_ready stalls ----
        do_reset();
        push_req(26'h2ABCDEF);
        receive_burst(26'h2ABCDEF, 1, BEATS, "toggle", gap, stalls);
        check("toggle stalled cycles", 32'(stalls), 32'd64);
        check("toggle stall_cycles", stall_cycles, 32'(STATS * 64));

        // ---- reset mid-burst with queued requests ----
        do_reset();
        push_req(26'h0111111);
        push_req(26'h0222222);
        push_req(26'h0333333);
        receive_burst(26'h0111111, 0, 10, "abort", gap, stalls);
        check("abort beat 10 presented", rsp_data, model_word(26'h0111111, 10));
        reset     = 1'b1;
        cmd_in    = 2'd1;               // must be ignored during reset
        add_in    = 26'h0444444;
        rsp_ready = 1'b1;
        tick();
        reset  = 1'b0;
        cmd_in = 2'd0;
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort rsp_data", rsp_data, 32'd0);
        check("abort reads_served", reads_served, 32'd0);
        count_valid(40, seen);
        check("abort no beats", 32'(seen), 32'd0);
        push_req(26'h0555555);
        receive_burst(26'h0555555, 2, BEATS, "after abort", gap, stalls);

        // ---- three bursts, statistics ----
        do_reset();
        rsp_ready = 1'b1;
        push_req(26'h00000A1);
        push_req(26'h00000B2);
        push_req(26'h00000C3);
        receive_burst(26'h00000A1, 0, BEATS, "three 0", gap, stalls);
        receive_burst(26'h00000B2, 0, BEATS, "three 1", gap, stalls);
        receive_burst(26'h00000C3, 0, BEATS, "three 2", gap, stalls);
        check("three reads_served", reads_served, 32'(STATS * 3));
        check("three stall_cycles", stall_cycles, 32'd0);

        // ---- randomized batches against the queue model ----
        do_reset();
        total = 0;
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(1, DEPTH);
            rsp_ready = 1'b0;
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 2) == 0) begin
                    cmd_in = 2'($urandom_range(2, 3));
                    add_in = 26'($urandom);
                    tick();
                end
                check($sformatf("rand %0d req_ready %0d", it, j), 32'(req_ready), 32'd1);
                qline.push_back(26'($urandom));
                push_req(qline[$]);
            end
            for (int j = 0; j < k; j++) begin
                receive_burst(qline.pop_front(), 2, BEATS, $sformatf("rand %0d.%0d", it, j),
                              gap, stalls);
                if (j > 0) check($sformatf("rand %0d.%0d gap", it, j), 32'(gap), 32'(LATENCY));
            end
            total += k;
        end
        check("rand reads_served", reads_served, 32'(STATS * total));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
